reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the processor datapath; successor to the fixed 16-entry file.
- Four registered read ports (Rn, Rs, Rm, Rd operand fetch) and one write port (ALU/DMEM writeback).
- Top register doubles as the program counter.
- Adds same-cycle write bypass, stall hold, PC-write arbitration and asynchronous reset.

Parameters:
- DATA_W, 32: register and data width in bits.
- NREGS, 16: number of registers; power of 2, minimum 4.
- ADDR_W, $clog2(NREGS): register address width (derived; do not override).
- RESET_PC, 0: value loaded into the PC register (index NREGS-1) on reset.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- rd_addr_n  in  ADDR_W  read address, port n.
- rd_addr_s  in  ADDR_W  read address, port s.
- rd_addr_m  in  ADDR_W  read address, port m.
- rd_addr_d  in  ADDR_W  read address, port d.
- wr_en  in  1  writeback enable.
- wr_addr  in  ADDR_W  writeback register index.
- wr_data  in  DATA_W  writeback data.
- pc_en  in  1  load pc_next into the PC register.
- pc_next  in  DATA_W  next PC value.
- stall  in  1  freeze read outputs and PC advance.
- rn_data  out  DATA_W  registered read data, port n.
- rs_data  out  DATA_W  registered read data, port s.
- rm_data  out  DATA_W  registered read data, port m.
- rd_data  out  DATA_W  registered read data, port d.
- pc_out  out  DATA_W  current PC register contents (direct view of register NREGS-1).

Behaviour:
Reset:
- RESET_N low asynchronously clears registers 0..NREGS-2 and all four read-data outputs to 0.
- PC register is set to RESET_PC; pc_out = RESET_PC.
- Reset takes effect immediately, including mid-write; the write in flight is lost.

Write port:
- wr_en=1 stores wr_data into register wr_addr at the clock edge.
- wr_addr=NREGS-1 writes the PC.

PC update, evaluated per cycle in priority order:
- (1) wr_en=1 and wr_addr=NREGS-1: PC <= wr_data, overriding pc_en and stall.
- (2) Otherwise, if pc_en=1 and stall=0: PC <= pc_next.
- (3) Otherwise PC holds.

Reads:
- Each rX_data is registered, one-cycle latency: the value sampled at edge k appears after edge k.
- Write-first bypass: if wr_en=1 and a read address equals wr_addr in the same cycle, that port captures wr_data, not the old contents.
- Reading index NREGS-1 returns the value the PC register will hold after the same edge: wr_data under rule (1), pc_next under rule (2), old PC under rule (3).
- All four ports are independent; any or all may address the same register, with identical results.

Stall:
- stall=1: all rX_data hold their previous values and rule (2) is suppressed.
- Register writes still commit; a held output is not refreshed by that write.
- The first non-stalled cycle re-reads with bypass as normal.

Other:
- Out-of-range addresses cannot occur (NREGS is a power of 2).
- Implementation is flops only; no memory-block inference is required.
- The PC register is kept separate from the data array.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, with no bypass, even when wr_addr=0 and wr_en=1.
- Undefined: register 0 is an ordinary read/write register.

Test Plan:
- Reset: with RESET_PC=16'h0100, pulse RESET_N low between clock edges -> pc_out=0x100 and all rX_data=0 immediately, with no clock edge needed.
- Write then read: write 0xDEADBEEF to R3; next cycle rd_addr_n=3 -> rn_data=0xDEADBEEF one cycle later.
- Bypass: same cycle, wr_en=1, wr_addr=5, wr_data=0x12345678, all four read addresses=5 -> all four outputs=0x12345678 after that edge.
- PC arbitration: pc_en=1, pc_next=0x104, and wr_en=1 to R15 with 0x200 in the same cycle -> pc_out=0x200; next cycle pc_en=1, pc_next=0x204, no write -> pc_out=0x204.
- Stall: stall=1 for 3 cycles with pc_en=1 and a write of 0x55 to R2 while rd_addr_s=2:
  - rs_data and pc_out unchanged throughout the stall;
  - stall drops -> rs_data=0x55 after the next edge.
- Zero register, macro defined: write 0xFFFF to R0 -> rn_data reads 0, including the same-cycle bypass case. Macro undefined -> reads 0xFFFF.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: four registered read ports, one write port, top register is the PC.
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int NREGS    = 16,
   parameter int ADDR_W   = $clog2(NREGS),
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] rd_addr_n,
   input  logic [ADDR_W-1:0] rd_addr_s,
   input  logic [ADDR_W-1:0] rd_addr_m,
   input  logic [ADDR_W-1:0] rd_addr_d,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pc_en,
   input  logic [DATA_W-1:0] pc_next,
   input  logic              stall,
   output logic [DATA_W-1:0] rn_data,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rm_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] pc_out
);

   localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS - 1);

   logic [DATA_W-1:0] regs [0:NREGS-2];
   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] pc_d;
   logic              pc_wr_hit;

   assign pc_wr_hit = wr_en && (wr_addr == PC_IDX);

   // Writeback to the PC outranks the sequential advance and ignores stall.
   always_comb begin
      pc_d = pc_q;
      if (pc_wr_hit)
         pc_d = wr_data;
      else if (pc_en && !stall)
         pc_d = pc_next;
   end

   // Value a read port captures: post-edge PC, or write-first bypass into the array.
   function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      if (addr == PC_IDX)
         val = pc_d;
`ifdef REGFILE_ZERO_REG_EN
      else if (addr == '0)
         val = '0;
`endif
      else if (wr_en && (wr_addr == addr))
         val = wr_data;
      else
         val = regs[addr];
      return val;
   endfunction

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NREGS - 1; i++)
            regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS - 1; i++) begin
`ifdef REGFILE_ZERO_REG_EN
            if (i != 0 && wr_en && (wr_addr == ADDR_W'(i)))
               regs[i] <= wr_data;
`else
            if (wr_en && (wr_addr == ADDR_W'(i)))
               regs[i] <= wr_data;
`endif
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         rn_data <= '0;
         rs_data <= '0;
         rm_data <= '0;
         rd_data <= '0;
      end else if (!stall) begin
         rn_data <= read_sel(rd_addr_n);
         rs_data <= read_sel(rd_addr_s);
         rm_data <= read_sel(rd_addr_m);
         rd_data <= read_sel(rd_addr_d);
      end
   end

   assign pc_out = pc_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, write/read, bypass, PC arbitration, stall, zero register.
module tb_reg_file_mp;

   localparam int DATA_W = 32;
   localparam int NREGS  = 16;
   localparam int ADDR_W = 4;
   localparam logic [DATA_W-1:0] RESET_PC = 32'h0000_0100;

   logic              CLOCK_50;
   logic              RESET_N;
   logic [ADDR_W-1:0] rd_addr_n, rd_addr_s, rd_addr_m, rd_addr_d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              pc_en;
   logic [DATA_W-1:0] pc_next;
   logic              stall;
   logic [DATA_W-1:0] rn_data, rs_data, rm_data, rd_data, pc_out;

   int total = 0;
   int bad   = 0;

   reg_file_mp #(
      .DATA_W   (DATA_W),
      .NREGS    (NREGS),
      .RESET_PC (RESET_PC)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .rd_addr_n (rd_addr_n),
      .rd_addr_s (rd_addr_s),
      .rd_addr_m (rd_addr_m),
      .rd_addr_d (rd_addr_d),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .pc_en     (pc_en),
      .pc_next   (pc_next),
      .stall     (stall),
      .rn_data   (rn_data),
      .rs_data   (rs_data),
      .rm_data   (rm_data),
      .rd_data   (rd_data),
      .pc_out    (pc_out)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      RESET_N = 1'b1;
      rd_addr_n = '0; rd_addr_s = '0; rd_addr_m = '0; rd_addr_d = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      pc_en = 1'b0; pc_next = '0; stall = 1'b0;

      // Asynchronous reset between edges
      #2 RESET_N = 1'b0;
      #1;
      check("rst_pc", pc_out, 32'h0000_0100);
      check("rst_rn", rn_data, 32'h0);
      check("rst_rs", rs_data, 32'h0);
      check("rst_rm", rm_data, 32'h0);
      check("rst_rd", rd_data, 32'h0);
      tick();
      RESET_N = 1'b1;

      // Write R3, then read it back
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
      tick();
      check("pc_hold_after_rst", pc_out, 32'h0000_0100);
      wr_en = 1'b0; rd_addr_n = 4'd3; rd_addr_s = 4'd1;
      tick();
      check("wr_rd_r3", rn_data, 32'hDEAD_BEEF);
      check("rd_r1_zero", rs_data, 32'h0);

      // Same-cycle bypass on all four ports
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234_5678;
      rd_addr_n = 4'd5; rd_addr_s = 4'd5; rd_addr_m = 4'd5; rd_addr_d = 4'd5;
      tick();
      check("byp_rn", rn_data, 32'h1234_5678);
      check("byp_rs", rs_data, 32'h1234_5678);
      check("byp_rm", rm_data, 32'h1234_5678);
      check("byp_rd", rd_data, 32'h1234_5678);

      // PC arbitration: writeback to R15 beats pc_en
      pc_en = 1'b1; pc_next = 32'h104;
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h200;
      rd_addr_d = 4'd15;
      tick();
      check("pc_wr_wins", pc_out, 32'h200);
      check("rd_pc_wr", rd_data, 32'h200);
      wr_en = 1'b0; pc_next = 32'h204;
      tick();
      check("pc_advance", pc_out, 32'h204);
      check("rd_pc_adv", rd_data, 32'h204);
      check("r5_still", rs_data, 32'h1234_5678);

      // Stall for 3 cycles with pc_en and a write to R2
      stall = 1'b1; pc_next = 32'h300;
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h55;
      rd_addr_s = 4'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_rs_hold", rs_data, 32'h1234_5678);
         check("stall_pc_hold", pc_out, 32'h204);
         check("stall_rd_hold", rd_data, 32'h204);
      end
      stall = 1'b0; wr_en = 1'b0; pc_en = 1'b0;
      tick();
      check("unstall_rs", rs_data, 32'h55);
      check("unstall_pc", pc_out, 32'h204);

      // PC writeback overrides stall
      stall = 1'b1; pc_en = 1'b1; pc_next = 32'h500;
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h400;
      tick();
      check("stall_pc_wr", pc_out, 32'h400);
      check("stall_rs_hold2", rs_data, 32'h55);
      stall = 1'b0; pc_en = 1'b0; wr_en = 1'b0;

      // Register 0: same-cycle bypass then plain read
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0000_FFFF;
      rd_addr_n = 4'd0;
      tick();
`ifdef REGFILE_ZERO_REG_EN
      check("r0_bypass", rn_data, 32'h0);
`else
      check("r0_bypass", rn_data, 32'h0000_FFFF);
`endif
      wr_en = 1'b0; rd_addr_m = 4'd0;
      tick();
`ifdef REGFILE_ZERO_REG_EN
      check("r0_read", rm_data, 32'h0);
`else
      check("r0_read", rm_data, 32'h0000_FFFF);
`endif

      // Reset mid-write: in-flight write lost, array cleared
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hAAAA_AAAA;
      #3 RESET_N = 1'b0;
      #1;
      check("rst2_pc", pc_out, 32'h0000_0100);
      check("rst2_rn", rn_data, 32'h0);
      wr_en = 1'b0;
      #2 RESET_N = 1'b1;
      rd_addr_n = 4'd7; rd_addr_m = 4'd3; rd_addr_s = 4'd2;
      tick();
      check("rst2_r7", rn_data, 32'h0);
      check("rst2_r3", rm_data, 32'h0);
      check("rst2_r2", rs_data, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
